// File: rtl/uart_mem_pkg.sv
// Shared opcodes and FSM encoding for the UART-to-memory command bridge.
package uart_mem_pkg;

    localparam logic [7:0] OP_SET_ADDR  = 8'h01;
    localparam logic [7:0] OP_SET_WDATA = 8'h02;
    localparam logic [7:0] OP_WRITE     = 8'h03;
    localparam logic [7:0] OP_GET_RDATA = 8'h04;
    localparam logic [7:0] OP_READ      = 8'h05;
    localparam logic [7:0] OP_SET_BE    = 8'h06;
    localparam logic [7:0] OP_STATUS    = 8'h07;
    localparam logic [7:0] RSP_ERR      = 8'hEE;

    typedef enum logic [2:0] {
        StCollect,
        StExec,
        StMemIssue,
        StMemWait,
        StResp
    } state_e;

endpackage

// File: rtl/resp_serializer.sv
// Shifts out an (NB+1)-byte response one byte per tx_ready, header byte first,
// with one guard cycle after every tx_start so the transmitter can go busy.
module resp_serializer #(
    parameter int unsigned NB = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              load,
    input  logic [8*(NB+1)-1:0] load_data,
    input  logic              tx_ready,
    output logic              tx_start,
    output logic [7:0]        tx_data,
    output logic              done
);
    localparam int unsigned W    = 8 * (NB + 1);
    localparam int unsigned CntW = $clog2(NB + 2);

    typedef enum logic [1:0] {SerIdle, SerWait, SerGuard} ser_e;

    ser_e            state_q, state_d;
    logic [W-1:0]    shift_q, shift_d;
    logic [CntW-1:0] cnt_q, cnt_d;
    logic            tx_start_q, tx_start_d;
    logic [7:0]      tx_data_q, tx_data_d;

    always_comb begin
        state_d    = state_q;
        shift_d    = shift_q;
        cnt_d      = cnt_q;
        tx_start_d = 1'b0;
        tx_data_d  = tx_data_q;
        done       = 1'b0;
        unique case (state_q)
            SerIdle: begin
                if (load) begin
                    shift_d = load_data;
                    cnt_d   = CntW'(NB + 1);
                    state_d = SerWait;
                end
            end
            SerWait: begin
                if (tx_ready) begin
                    tx_start_d = 1'b1;
                    tx_data_d  = shift_q[W-1 -: 8];
                    shift_d    = shift_q << 8;
                    cnt_d      = cnt_q - CntW'(1);
                    state_d    = SerGuard;
                end
            end
            SerGuard: begin
                // tx_ready is not looked at here: the transmitter is still latching tx_start.
                if (cnt_q == '0) begin
                    done    = 1'b1;
                    state_d = SerIdle;
                end else begin
                    state_d = SerWait;
                end
            end
            default: state_d = SerIdle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= SerIdle;
            shift_q    <= '0;
            cnt_q      <= '0;
            tx_start_q <= 1'b0;
            tx_data_q  <= '0;
        end else begin
            state_q    <= state_d;
            shift_q    <= shift_d;
            cnt_q      <= cnt_d;
            tx_start_q <= tx_start_d;
            tx_data_q  <= tx_data_d;
        end
    end

    assign tx_start = tx_start_q;
    assign tx_data  = tx_data_q;

endmodule

// File: rtl/uart_mem_bridge.sv
// Parses opcode+payload frames from a UART byte stream, runs single-dword memory
// reads/writes with a timeout, and answers every command with a framed response.
module uart_mem_bridge
    import uart_mem_pkg::*;
#(
    parameter int unsigned DATA_W   = 32,
    parameter int unsigned ADDR_W   = 32,
    parameter int unsigned FRAME_TO = 120000,
    parameter int unsigned MEM_TO   = 4096,
    parameter int unsigned AUTOINC  = 1
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                rx_valid,
    input  logic [7:0]          rx_data,
    input  logic                tx_ready,
    output logic                tx_start,
    output logic [7:0]          tx_data,
    output logic                mem_rd_req,
    output logic                mem_wr_req,
    output logic [ADDR_W-1:0]   mem_addr,
    output logic [DATA_W-1:0]   mem_wr_d,
    output logic [DATA_W/8-1:0] mem_wr_byte_en,
    output logic [5:0]          mem_rd_num_dwords,
    input  logic [DATA_W-1:0]   mem_rd_d,
    input  logic                mem_rd_rdy,
    input  logic                mem_busy
);
    localparam int unsigned NB   = DATA_W / 8;
    localparam int unsigned FW   = 8 * (NB + 1);
    localparam int unsigned CntW = $clog2(NB + 2);
    localparam int unsigned FtoW = $clog2(FRAME_TO + 1);
    localparam int unsigned MtoW = $clog2(MEM_TO + 1);

    state_e            state_q, state_d;
    logic [CntW-1:0]   count_q, count_d;
    logic [FW-1:0]     frame_q, frame_d;
    logic [FtoW-1:0]   fto_q, fto_d;
    logic [MtoW-1:0]   mto_q, mto_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [DATA_W-1:0] wdata_q, wdata_d, rcap_q, rcap_d;
    logic [NB-1:0]     be_q, be_d;
    logic              ovf_q, ovf_d, tmo_q, tmo_d, is_rd_q, is_rd_d, busy_prev_q;
    logic              rd_req_q, rd_req_d, wr_req_q, wr_req_d;
    logic              resp_load, resp_done;
    logic [7:0]        resp_hdr, opcode;
    logic [DATA_W-1:0] resp_pay, payload;
    logic              mem_done;

    assign opcode   = frame_q[FW-1 -: 8];
    assign payload  = frame_q[DATA_W-1:0];
    assign mem_done = is_rd_q ? mem_rd_rdy : (busy_prev_q && !mem_busy);

    always_comb begin
        state_d   = state_q;
        count_d   = count_q;
        frame_d   = frame_q;
        fto_d     = fto_q;
        mto_d     = mto_q;
        addr_d    = addr_q;
        wdata_d   = wdata_q;
        rcap_d    = rcap_q;
        be_d      = be_q;
        ovf_d     = ovf_q;
        tmo_d     = tmo_q;
        is_rd_d   = is_rd_q;
        rd_req_d  = 1'b0;
        wr_req_d  = 1'b0;
        resp_load = 1'b0;
        resp_hdr  = RSP_ERR;
        resp_pay  = '0;
        if (state_q != StCollect && rx_valid) ovf_d = 1'b1;
        unique case (state_q)
            StCollect: begin
                if (rx_valid) begin
                    frame_d = {frame_q[FW-9:0], rx_data};
                    fto_d   = '0;
                    if (count_q == CntW'(NB)) begin
                        count_d = '0;
                        state_d = StExec;
                    end else begin
                        count_d = count_q + CntW'(1);
                    end
                end else if (count_q != '0) begin
                    // Stalled partial frame: drop it so the next byte starts a fresh frame.
                    if (fto_q == FtoW'(FRAME_TO - 1)) begin
                        count_d = '0;
                        fto_d   = '0;
                    end else begin
                        fto_d = fto_q + FtoW'(1);
                    end
                end
            end
            StExec: begin
                resp_load = 1'b1;
                resp_hdr  = opcode;
                resp_pay  = payload;
                state_d   = StResp;
                case (opcode)
                    OP_SET_ADDR: begin
                        addr_d   = payload[ADDR_W-1:0];
                        resp_pay = DATA_W'(payload[ADDR_W-1:0]);
                    end
                    OP_SET_WDATA: wdata_d = payload;
                    OP_WRITE, OP_READ: begin
                        resp_load = 1'b0;
                        is_rd_d   = (opcode == OP_READ);
                        state_d   = StMemIssue;
                    end
                    OP_GET_RDATA: resp_pay = rcap_q;
                    OP_SET_BE:    be_d = payload[NB-1:0];
                    OP_STATUS: begin
                        resp_pay = DATA_W'({ovf_q, tmo_q, mem_busy});
                        tmo_d    = 1'b0;
                        ovf_d    = rx_valid;
                    end
                    default: begin
                        resp_hdr = RSP_ERR;
                        resp_pay = '0;
                    end
                endcase
            end
            StMemIssue: begin
                if (!mem_busy) begin
                    rd_req_d = is_rd_q;
                    wr_req_d = !is_rd_q;
                    mto_d    = '0;
                    state_d  = StMemWait;
                end
            end
            StMemWait: begin
                mto_d = mto_q + MtoW'(1);
                if (mem_done) begin
                    resp_load = 1'b1;
                    resp_hdr  = is_rd_q ? OP_READ : OP_WRITE;
                    resp_pay  = is_rd_q ? mem_rd_d : wdata_q;
                    if (is_rd_q) rcap_d = mem_rd_d;
                    if (AUTOINC != 0) addr_d = addr_q + ADDR_W'(1);
                    state_d = StResp;
                end else if (mto_q == MtoW'(MEM_TO - 1)) begin
                    tmo_d     = 1'b1;
                    resp_load = 1'b1;
                    state_d   = StResp;
                end
            end
            StResp: begin
                if (resp_done) state_d = StCollect;
            end
            default: state_d = StCollect;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= StCollect;
            count_q     <= '0;
            frame_q     <= '0;
            fto_q       <= '0;
            mto_q       <= '0;
            addr_q      <= '0;
            wdata_q     <= '0;
            rcap_q      <= '0;
            be_q        <= '1;
            ovf_q       <= 1'b0;
            tmo_q       <= 1'b0;
            is_rd_q     <= 1'b0;
            busy_prev_q <= 1'b0;
            rd_req_q    <= 1'b0;
            wr_req_q    <= 1'b0;
        end else begin
            state_q     <= state_d;
            count_q     <= count_d;
            frame_q     <= frame_d;
            fto_q       <= fto_d;
            mto_q       <= mto_d;
            addr_q      <= addr_d;
            wdata_q     <= wdata_d;
            rcap_q      <= rcap_d;
            be_q        <= be_d;
            ovf_q       <= ovf_d;
            tmo_q       <= tmo_d;
            is_rd_q     <= is_rd_d;
            busy_prev_q <= mem_busy;
            rd_req_q    <= rd_req_d;
            wr_req_q    <= wr_req_d;
        end
    end

    resp_serializer #(
        .NB (NB)
    ) u_ser (
        .clk       (clk),
        .reset     (reset),
        .load      (resp_load),
        .load_data ({resp_hdr, resp_pay}),
        .tx_ready  (tx_ready),
        .tx_start  (tx_start),
        .tx_data   (tx_data),
        .done      (resp_done)
    );

    assign mem_rd_req        = rd_req_q;
    assign mem_wr_req        = wr_req_q;
    assign mem_addr          = addr_q;
    assign mem_wr_d          = wdata_q;
    assign mem_wr_byte_en    = be_q;
    assign mem_rd_num_dwords = 6'd1;

endmodule

// File: tb/tb_uart_mem_bridge.sv
// Bench for uart_mem_bridge: table of register commands plus memory, timeout,
// resync, tx pacing and reset sequences, checked against a tx byte scoreboard.
module tb_uart_mem_bridge;

    localparam int unsigned DATA_W   = 32;
    localparam int unsigned ADDR_W   = 32;
    localparam int unsigned FRAME_TO = 200;
    localparam int unsigned MEM_TO   = 100;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        rx_valid = 1'b0;
    logic [7:0]  rx_data = 8'h00;
    logic        tx_ready = 1'b1;
    logic        tx_start;
    logic [7:0]  tx_data;
    logic        mem_rd_req, mem_wr_req;
    logic [31:0] mem_addr, mem_wr_d;
    logic [3:0]  mem_wr_byte_en;
    logic [5:0]  mem_rd_num_dwords;
    logic [31:0] mem_rd_d = 32'h0;
    logic        mem_rd_rdy = 1'b0;
    logic        mem_busy = 1'b0;

    int errors = 0;
    int checks = 0;
    logic [7:0] exp_q[$];

    int tx_cnt = 0, tx_busy = 0;
    bit tx_hold = 0;
    int wr_pulses = 0, busy_cnt = 0, rd_cnt = 0;
    bit rd_respond = 1;
    logic [31:0] rd_value = 32'h0, exp_wr_addr = 32'h0, exp_wr_data = 32'h0;
    int c0, c1, n;

    typedef struct {
        logic [7:0]  op;
        logic [31:0] pay;
        logic [7:0]  hdr;
        logic [31:0] rsp;
        logic [3:0]  be;
    } vec_t;
    vec_t vecs[7];

    uart_mem_bridge #(
        .DATA_W   (DATA_W),
        .ADDR_W   (ADDR_W),
        .FRAME_TO (FRAME_TO),
        .MEM_TO   (MEM_TO),
        .AUTOINC  (1)
    ) dut (
        .clk               (clk),
        .reset             (reset),
        .rx_valid          (rx_valid),
        .rx_data           (rx_data),
        .tx_ready          (tx_ready),
        .tx_start          (tx_start),
        .tx_data           (tx_data),
        .mem_rd_req        (mem_rd_req),
        .mem_wr_req        (mem_wr_req),
        .mem_addr          (mem_addr),
        .mem_wr_d          (mem_wr_d),
        .mem_wr_byte_en    (mem_wr_byte_en),
        .mem_rd_num_dwords (mem_rd_num_dwords),
        .mem_rd_d          (mem_rd_d),
        .mem_rd_rdy        (mem_rd_rdy),
        .mem_busy          (mem_busy)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got=%0h required=%0h", name, act, exp);
        end
    endtask

    // UART transmitter model: busy for 3 cycles after each tx_start.
    initial forever begin
        @(negedge clk);
        if (tx_start) begin
            tx_cnt++;
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL tx_unexpected got=%02h required=none", tx_data);
            end else begin
                check("tx_byte", {56'h0, tx_data}, {56'h0, exp_q.pop_front()});
            end
            tx_busy = 3;
        end else if (tx_busy > 0) begin
            tx_busy--;
        end
        tx_ready = (tx_busy == 0) && !tx_hold;
    end

    // Memory model: writes hold busy 10 cycles, reads answer after 20 cycles.
    initial forever begin
        @(negedge clk);
        mem_rd_rdy = 1'b0;
        if (mem_wr_req) begin
            wr_pulses++;
            check("wr_addr", {32'h0, mem_addr}, {32'h0, exp_wr_addr});
            check("wr_data", {32'h0, mem_wr_d}, {32'h0, exp_wr_data});
            busy_cnt = 10;
            mem_busy = 1'b1;
        end else if (busy_cnt > 0) begin
            busy_cnt--;
            if (busy_cnt == 0) mem_busy = 1'b0;
        end
        if (mem_rd_req && rd_respond) begin
            rd_cnt = 20;
        end else if (rd_cnt > 0) begin
            rd_cnt--;
            if (rd_cnt == 0) begin
                mem_rd_rdy = 1'b1;
                mem_rd_d   = rd_value;
            end
        end
    end

    task automatic send_frame(input logic [7:0] op, input logic [31:0] pay);
        logic [39:0] f;
        f = {op, pay};
        for (int i = 4; i >= 0; i--) begin
            @(negedge clk);
            rx_valid = 1'b1;
            rx_data  = f[i*8 +: 8];
            @(negedge clk);
            rx_valid = 1'b0;
        end
    endtask

    task automatic expect_resp(input logic [7:0] hdr, input logic [31:0] pay);
        exp_q.push_back(hdr);
        for (int i = 3; i >= 0; i--) exp_q.push_back(pay[i*8 +: 8]);
    endtask

    task automatic wait_idle(input string name);
        int k;
        k = 0;
        while (exp_q.size() != 0 && k < 3000) begin
            @(negedge clk);
            k++;
        end
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL %s response_timeout got=%0d_pending required=0", name, exp_q.size());
            exp_q.delete();
        end
        repeat (6) @(negedge clk);
    endtask

    initial begin
        vecs[0] = '{8'h04, 32'h0000_0000, 8'h04, 32'h0000_0000, 4'hF};
        vecs[1] = '{8'h07, 32'h0000_0000, 8'h07, 32'h0000_0000, 4'hF};
        vecs[2] = '{8'h06, 32'h0000_0005, 8'h06, 32'h0000_0005, 4'h5};
        vecs[3] = '{8'h06, 32'h0000_000F, 8'h06, 32'h0000_000F, 4'hF};
        vecs[4] = '{8'h7F, 32'h1234_5678, 8'hEE, 32'h0000_0000, 4'hF};
        vecs[5] = '{8'h02, 32'hDEAD_BEEF, 8'h02, 32'hDEAD_BEEF, 4'hF};
        vecs[6] = '{8'h01, 32'h0000_0123, 8'h01, 32'h0000_0123, 4'hF};

        repeat (3) @(negedge clk);
        check("rst_tx_start", {63'h0, tx_start}, 64'h0);
        check("rst_tx_data", {56'h0, tx_data}, 64'h0);
        check("rst_rd_req", {63'h0, mem_rd_req}, 64'h0);
        check("rst_wr_req", {63'h0, mem_wr_req}, 64'h0);
        check("rst_addr", {32'h0, mem_addr}, 64'h0);
        check("rst_wr_d", {32'h0, mem_wr_d}, 64'h0);
        check("rst_be", {60'h0, mem_wr_byte_en}, 64'hF);
        check("rst_num_dw", {58'h0, mem_rd_num_dwords}, 64'h1);
        reset = 1'b0;

        foreach (vecs[i]) begin
            expect_resp(vecs[i].hdr, vecs[i].rsp);
            send_frame(vecs[i].op, vecs[i].pay);
            wait_idle("vec");
            check("vec_be", {60'h0, mem_wr_byte_en}, {60'h0, vecs[i].be});
        end
        check("set_addr", {32'h0, mem_addr}, 64'h123);
        check("set_wdata", {32'h0, mem_wr_d}, 64'hDEAD_BEEF);

        // Write through memory model.
        exp_wr_addr = 32'h123;
        exp_wr_data = 32'hDEAD_BEEF;
        expect_resp(8'h03, 32'hDEAD_BEEF);
        send_frame(8'h03, 32'h0);
        wait_idle("write");
        check("wr_pulses", wr_pulses, 1);
        check("addr_inc_wr", {32'h0, mem_addr}, 64'h124);

        // Read, then read-capture readback.
        rd_value = 32'hCAFE_F00D;
        expect_resp(8'h05, 32'hCAFE_F00D);
        send_frame(8'h05, 32'h0);
        wait_idle("read");
        check("addr_inc_rd", {32'h0, mem_addr}, 64'h125);
        expect_resp(8'h04, 32'hCAFE_F00D);
        send_frame(8'h04, 32'h0);
        wait_idle("get_rdata");

        // Read that never completes.
        rd_respond = 0;
        expect_resp(8'hEE, 32'h0);
        send_frame(8'h05, 32'h0);
        wait_idle("mem_timeout");
        rd_respond = 1;
        check("addr_no_inc_to", {32'h0, mem_addr}, 64'h125);
        expect_resp(8'h07, 32'h0000_0002);
        send_frame(8'h07, 32'h0);
        wait_idle("status_to");
        expect_resp(8'h07, 32'h0000_0000);
        send_frame(8'h07, 32'h0);
        wait_idle("status_clr");

        // Byte arriving while a response is pending sets overflow.
        expect_resp(8'hEE, 32'h0);
        send_frame(8'h7F, 32'h0);
        repeat (3) @(negedge clk);
        rx_valid = 1'b1;
        rx_data  = 8'h55;
        @(negedge clk);
        rx_valid = 1'b0;
        wait_idle("ovf_resp");
        expect_resp(8'h07, 32'h0000_0004);
        send_frame(8'h07, 32'h0);
        wait_idle("status_ovf");

        // Partial frame abandoned past FRAME_TO.
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            rx_valid = 1'b1;
            rx_data  = (i == 0) ? 8'h01 : 8'h00;
            @(negedge clk);
            rx_valid = 1'b0;
        end
        repeat (FRAME_TO + 1) @(negedge clk);
        expect_resp(8'h01, 32'h0000_0234);
        send_frame(8'h01, 32'h0000_0234);
        wait_idle("resync");
        check("resync_addr", {32'h0, mem_addr}, 64'h234);

        // tx_ready held low: nothing goes out until it rises.
        tx_hold = 1;
        @(negedge clk);
        c0 = tx_cnt;
        expect_resp(8'hEE, 32'h0);
        send_frame(8'h7F, 32'hAABB_CCDD);
        repeat (50) @(negedge clk);
        check("hold_no_tx", tx_cnt, c0);
        tx_hold = 0;
        wait_idle("hold_release");

        // Reset in the middle of a response.
        c0 = tx_cnt;
        expect_resp(8'hEE, 32'h0);
        send_frame(8'h7F, 32'h0);
        n = 0;
        while (tx_cnt == c0 && n < 200) begin
            @(negedge clk);
            n++;
        end
        check("resp_started", tx_cnt, c0 + 1);
        reset = 1'b1;
        exp_q.delete();
        repeat (2) @(negedge clk);
        reset = 1'b0;
        c1 = tx_cnt;
        repeat (30) @(negedge clk);
        check("rst_no_tx", tx_cnt, c1);
        check("rst2_addr", {32'h0, mem_addr}, 64'h0);
        check("rst2_be", {60'h0, mem_wr_byte_en}, 64'hF);
        expect_resp(8'h04, 32'h0);
        send_frame(8'h04, 32'h0);
        wait_idle("after_reset");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/uart_mem_bridge.md
Name: uart_mem_bridge

Overview:
- Parametrised UART-to-memory command bridge between `uart_rx`/`uart_tx` and `hyper_xface`.
- Parses fixed-length command frames of one opcode byte plus DATA_W/8 payload bytes.
- Issues single-dword read and write requests with a timeout, and returns a framed response for every command.
- Adds over the previous ad-hoc logic: width generality, byte-enable control, address auto-increment, frame resync, memory timeout, a status command, and a tx_ready-paced multi-byte response.

Parameters:
- DATA_W, 32: data/payload width in bits; multiple of 8, range 8..64; NB = DATA_W/8.
- ADDR_W, 32: memory address width; ADDR_W <= DATA_W.
- FRAME_TO, 120000: idle cycles mid-frame before the partial frame is discarded.
- MEM_TO, 4096: cycles from request issue before a memory op is declared timed out.
- AUTOINC, 1: 1 = increment address by 1 after a successful read or write.

Ports:
- clk  in  1  system clock
- reset  in  1  synchronous, active-high reset
- rx_valid  in  1  one-cycle strobe, rx_data valid
- rx_data  in  8  received byte
- tx_ready  in  1  transmitter idle
- tx_start  out  1  one-cycle strobe to transmit tx_data
- tx_data  out  8  byte to transmit, held until next tx_start
- mem_rd_req  out  1  one-cycle read request
- mem_wr_req  out  1  one-cycle write request
- mem_addr  out  ADDR_W  address register
- mem_wr_d  out  DATA_W  write data register
- mem_wr_byte_en  out  NB  byte enables
- mem_rd_num_dwords  out  6  constant 1
- mem_rd_d  in  DATA_W  read data
- mem_rd_rdy  in  1  one-cycle read-data-valid strobe
- mem_busy  in  1  interface busy

Behaviour:
- Reset values:
  - tx_start, mem_rd_req, mem_wr_req, tx_data, mem_addr, mem_wr_d, rd_capture = 0.
  - mem_wr_byte_en = all ones.
  - overflow flag and timeout flag = 0.
  - Byte count = 0; state = COLLECT.
  - Reset mid-operation aborts everything. A pending response is not sent.
- States: COLLECT, EXEC, MEM_ISSUE, MEM_WAIT, RESP.
- COLLECT:
  - Each rx_valid shifts rx_data into a (NB+1)-byte frame register, MSB first; count increments.
  - The FRAME_TO counter resets on each byte and runs only while count != 0. On expiry, count = 0 and the bytes are discarded with no response.
  - When count reaches NB+1: count = 0, go to EXEC on the next cycle.
- rx_valid in any state other than COLLECT: byte dropped, overflow flag set (sticky until status read).
- EXEC: dispatch on the opcode in a single cycle. Payload P = DATA_W bits.
  - 0x01: mem_addr <= P[ADDR_W-1:0]; respond opcode + P zero-extended.
  - 0x02: mem_wr_d <= P; respond opcode + P.
  - 0x03: write; go to MEM_ISSUE.
  - 0x04: respond opcode + rd_capture.
  - 0x05: read; go to MEM_ISSUE.
  - 0x06: mem_wr_byte_en <= P[NB-1:0]; respond opcode + P.
  - 0x07: respond opcode + status {.., overflow, timeout, mem_busy} in P[2:0], other bits 0; clears both flags in the same cycle (a same-cycle set wins).
  - Other opcode: respond 0xEE + all-zero payload.
- MEM_ISSUE: wait for mem_busy == 0, then pulse the request for exactly one cycle; MEM_TO counter starts.
- MEM_WAIT:
  - Read completes on mem_rd_rdy; rd_capture <= mem_rd_d in the same cycle.
  - Write completes on the first mem_busy 1->0 transition after issue.
  - On completion: respond opcode + (rd_capture for read, mem_wr_d for write).
  - If AUTOINC = 1, mem_addr increments by 1 on completion, wrapping modulo 2^ADDR_W.
  - On MEM_TO expiry: timeout flag set, no address increment, respond 0xEE + zero payload.
  - mem_rd_rdy arriving in any other state is ignored.
- RESP: sends NB+1 bytes, header first, then payload MSB first.
  - Each byte: wait for tx_ready = 1, then pulse tx_start with tx_data valid.
  - Then one guard cycle, during which tx_ready is not sampled.
  - After the last byte, return to COLLECT.
- Latency: first tx_start is no earlier than 2 cycles after the final rx_valid of the frame (non-memory commands, tx_ready high).

Decomposition:
- Shared package `uart_mem_pkg`: opcode localparams (OP_SET_ADDR = 0x01 .. OP_STATUS = 0x07, RSP_ERR = 0xEE) and the state enum encoding.
- One natural sub-module: `resp_serializer` (load NB+1 bytes, tx_ready-paced shift out, done strobe).

Test Plan:
- Frame 01 00 00 01 23 -> mem_addr = 0x00000123; tx bytes 01 00 00 01 23.
- Frames 02 DE AD BE EF then 03 00 00 00 00, model drops busy after 10 cycles:
  - -> one mem_wr_req pulse with mem_addr = 0x123, mem_wr_d = 0xDEADBEEF;
  - -> response 03 DE AD BE EF; mem_addr = 0x124.
- Frame 05 x4, model returns rd_rdy with 0xCAFEF00D after 20 cycles -> response 05 CA FE F0 0D; then 04 frame -> 04 CA FE F0 0D.
- Read with model never asserting rd_rdy -> after MEM_TO cycles, response EE 00 00 00 00; 07 frame -> 07 00 00 00 02, flag cleared.
- Send 3 bytes, idle FRAME_TO+1 cycles, then a full 01 frame -> only one response; partial frame discarded.
- Unknown opcode 0x7F -> EE 00 00 00 00; with tx_ready held low 50 cycles, no tx_start until it rises; reset asserted mid-RESP -> tx_start stays 0, state returns to COLLECT.
